// File: rtl/arb_rr_lock.sv
// arb_rr_lock: registered round-robin / fixed-priority arbiter with grant locking.
// One winner at a time raises req_o downstream. The downstream ack_o is passed back
// to the winner as a one-hot ack_i, which is held until the winner releases it or
// until MAX_HOLD cycles pass while other requesters are waiting.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   req_i[N]    - per-channel requests, held high while the resource is wanted
//   fixed_mode  - 1: lowest index wins, 0: round-robin (sampled only when idle)
//   ack_i[N]    - one-hot grant to the winner (registered)
//   req_o       - request to the downstream resource (registered)
//   ack_o       - downstream acknowledge, honoured only while requesting
//   gnt_idx[IW] - index of the current or most recent winner (registered)
//   busy        - high while requesting or granted (registered)
module arb_rr_lock #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          fixed_mode,
  output logic [N-1:0]  ack_i,
  output logic          req_o,
  input  logic          ack_o,
  output logic [IW-1:0] gnt_idx,
  output logic          busy
);

  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;

  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  logic [1:0]    state, state_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [IW-1:0] gnt_d;
  logic [N-1:0]  ack_d;
  logic          req_o_d, busy_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  rr_off, rr_win, fx_win;
  logic [IW:0]    rr_sum;
  logic [N-1:0]   onehot_w;
  logic           w_req, others, preempt;

  // Winner search: rotate requests so ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = N'(req_dbl >> ptr);
    rr_off  = '0;
    fx_win  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) rr_off = IW'(i);
      if (req_i[i])   fx_win = IW'(i);
    end
    rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    if (32'(rr_sum) >= N) rr_win = IW'(32'(rr_sum) - N);
    else                  rr_win = IW'(rr_sum);
  end

  // Status of the latched winner and the preemption condition.
  always_comb begin
    onehot_w = N'(1) << gnt_idx;
    w_req    = req_i[gnt_idx];
    others   = |(req_i & ~onehot_w);
    preempt  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    hold_d  = hold_cnt;
    gnt_d   = gnt_idx;
    case (state)
      S_IDLE: begin
        if (|req_i) begin
          gnt_d   = fixed_mode ? fx_win : rr_win;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Withdrawal wins over a simultaneous acknowledge; ptr is left alone.
        if (!w_req) begin
          state_d = S_IDLE;
        end else if (ack_o) begin
          state_d = S_GRANT;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (!w_req || preempt) begin
          state_d = S_IDLE;
          ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack_d   = (state_d == S_GRANT) ? (N'(1) << gnt_d) : '0;
    req_o_d = (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      ack_i    <= '0;
      req_o    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
      gnt_idx  <= gnt_d;
      ack_i    <= ack_d;
      req_o    <= req_o_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_arb_rr_lock.sv
// tb_arb_rr_lock: directed bench for arb_rr_lock (N=8, MAX_HOLD=4) with a
// transaction-level reference model compared on every falling edge.
module tb_arb_rr_lock;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
  localparam int IW       = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_i;
  logic          fixed_mode;
  logic [N-1:0]  ack_i;
  logic          req_o;
  logic          ack_o;
  logic [IW-1:0] gnt_idx;
  logic          busy;

  arb_rr_lock #(.N(N), .MAX_HOLD(MAX_HOLD), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .fixed_mode(fixed_mode),
    .ack_i     (ack_i),
    .req_o     (req_o),
    .ack_o     (ack_o),
    .gnt_idx   (gnt_idx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int idx;
  int cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, who is asking, and for how long.
  int m_phase;  // 0 nobody, 1 winner asking downstream, 2 winner holds the grant
  int m_ptr;
  int m_w;
  int m_age;    // cycles the current grant has been visible on ack_i

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = fixed_mode ? k : (m_ptr + k) % N;
      if (req_i[c]) return c;
    end
    return 0;
  endfunction

  initial begin
    m_phase = 0; m_ptr = 0; m_w = 0; m_age = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_ptr = 0; m_w = 0; m_age = 0;
      end else begin
        case (m_phase)
          0: if (req_i != '0) begin m_w = pick(); m_phase = 1; end
          1: begin
            if (!req_i[m_w]) m_phase = 0;
            else if (ack_o) begin m_phase = 2; m_age = 1; end
          end
          default: begin
            if (!req_i[m_w] ||
                (m_age == MAX_HOLD && (req_i & ~(N'(1) << m_w)) != '0)) begin
              m_ptr   = (m_w + 1) % N;
              m_phase = 0;
            end else begin
              m_age++;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("ack_i",   ack_i,   (m_phase == 2) ? 32'(N'(1) << m_w) : 32'd0);
      chk("req_o",   req_o,   32'(m_phase != 0));
      chk("busy",    busy,    32'(m_phase != 0));
      chk("gnt_idx", gnt_idx, 32'(m_w));
      chk("ptr",     dut.ptr, 32'(m_ptr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(output int w);
    w = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack_i != '0) begin
        w = $clog2(ack_i);
        break;
      end
    end
    if (w < 0) begin
      total++;
      bad++;
      $display("FAIL wait_ack actual=no_grant required=grant at %0t", $time);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_i = '0; fixed_mode = 1'b0; ack_o = 1'b0;
    cyc(2);
    chk("rst_ack_i", ack_i, 0);
    chk("rst_req_o", req_o, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_gnt",   gnt_idx, 0);

    // Reset and first grant
    req_i = 8'b0010_0100; ack_o = 1'b1; rst = 1'b0;
    cyc(1);
    chk("first_req_o", req_o, 1);
    chk("first_ack_early", ack_i, 0);
    chk("first_gnt_idx", gnt_idx, 2);
    cyc(1);
    chk("first_ack_i", ack_i, 8'b0000_0100);
    req_i = '0;
    cyc(2);

    // Round-robin rotation with wrap
    rst_pulse();
    req_i = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      wait_ack(idx);
      chk("rr_order", idx, g % N);
      if (idx >= 0) begin
        cyc(2);
        req_i[idx] = 1'b0;
        cyc(1);
        req_i = 8'hFF;
      end
    end
    req_i = '0;
    cyc(2);

    // Fixed priority starves channel 7
    fixed_mode = 1'b1;
    req_i = 8'b1000_0010;
    for (int g = 0; g < 4; g++) begin
      wait_ack(idx);
      chk("fixed_win", idx, 1);
      req_i = 8'b1000_0000;
      cyc(1);
      req_i = 8'b1000_0010;
    end
    req_i = '0; fixed_mode = 1'b0;
    cyc(2);

    // Preemption after MAX_HOLD cycles
    rst_pulse();
    req_i = 8'b0000_1000;
    wait_ack(idx);
    chk("pre_first", idx, 3);
    req_i[5] = 1'b1;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_i == 8'b0000_1000) cnt++;
      else break;
    end
    chk("pre_hold_len", cnt, 4);
    wait_ack(idx);
    chk("pre_next", idx, 5);
    req_i = '0;
    cyc(3);

    // No preemption when nobody else waits
    rst_pulse();
    req_i = 8'b0000_1000;
    wait_ack(idx);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack_i == 8'b0000_1000) cnt++;
    end
    chk("hold_alone", cnt, 10);
    req_i = '0;
    cyc(2);

    // Withdrawal in REQ, and ack_o ignored while idle
    rst_pulse();
    ack_o = 1'b0;
    req_i = 8'b0000_0110;
    cyc(1);
    chk("wd_req_o", req_o, 1);
    chk("wd_gnt", gnt_idx, 1);
    cyc(2);
    chk("wd_no_ack", ack_i, 0);
    req_i = '0;
    cyc(1);
    chk("wd_idle", req_o, 0);
    chk("wd_ptr", dut.ptr, 0);
    ack_o = 1'b1;
    cyc(2);
    chk("idle_ack_pulse", ack_i, 0);
    req_i = 8'b0000_0110;
    wait_ack(idx);
    chk("wd_regrant", idx, 1);
    req_i = '0;
    cyc(2);

    // Asynchronous reset during GRANT
    req_i = 8'b0010_0000;
    wait_ack(idx);
    req_i = '0;
    cyc(2);
    req_i = 8'b0010_0000;
    wait_ack(idx);
    chk("ar_pre_grant", idx, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_ack_i", ack_i, 0);
    chk("ar_req_o", req_o, 0);
    chk("ar_busy",  busy,  0);
    chk("ar_ptr",   dut.ptr, 0);
    @(negedge clk);
    rst = 1'b0;
    req_i = 8'b0000_0011;
    wait_ack(idx);
    chk("ar_after", idx, 0);
    req_i = '0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
